// File: rtl/riscv_wb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_wb_pkg
//   Shared definitions for the register-bank write-back path: result source
//   encodings, load funct3 codes and the default datapath/register-index
//   widths used by both the read (decode) and write (write-back) sides.
// ---------------------------------------------------------------------------
package riscv_wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    // Result source selector carried with every completed instruction.
    // WB_RSV is never produced by a legal pipeline and behaves like WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3
    } wb_src_e;

    // Load width / signedness (funct3 of the load opcode)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/reg_writeback_load_align.sv
// ---------------------------------------------------------------------------
// wb_load_align
//   Purely combinational load formatter. Picks the addressed byte/half out of
//   an aligned load word, sign- or zero-extends it to XLEN, and flags loads
//   that are misaligned for their width or carry an unsupported funct3.
// Ports
//   funct3_i   load width/sign code
//   addr_lo_i  byte offset of the load inside the word
//   rdata_i    raw aligned load word
//   data_o     formatted value (don't-care when err_o is set)
//   err_o      misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module wb_load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        // Halfword position comes from addr bit 1 only; bit 0 is checked below.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
                err_o  = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o = {{(XLEN-16){1'b0}}, half_sel};
                err_o  = addr_lo_i[0];
            end
            F3_LW: begin
                data_o = rdata_i;
                err_o  = (addr_lo_i != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//   Write-back end of the register bank. Forms the final value of each
//   completed result (ALU, formatted load data, PC+4), buffers it in a small
//   in-order FIFO and drains the FIFO into the single register-file write
//   port whenever that port is not held by another agent.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   wb_valid / wb_ready         result handshake (wb_ready = count < DEPTH)
//   wb_rd, wb_src               destination register and value source
//   wb_funct3, wb_addr_lo       load width/sign and byte offset (MEM only)
//   alu_result, mem_rdata, pc   candidate values
//   rf_busy                     write port taken this cycle: drain stalls
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   wb_pending                  FIFO occupancy
//   err_load                    one-cycle pulse for a dropped bad load
//
// Build option
//   RISCV_WB_FORWARD_EN  adds fwd_valid / fwd_rd / fwd_data, exposing the
//                        youngest buffered entry for decode-stage bypass.
//                        Without it decode must stall on wb_pending != 0.
// ---------------------------------------------------------------------------
module reg_writeback
    import riscv_wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = 2,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [REG_AW-1:0]       wb_rd,
    input  logic [1:0]              wb_src,
    input  logic [2:0]              wb_funct3,
    input  logic [1:0]              wb_addr_lo,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic [XLEN-1:0]         pc,
    input  logic                    rf_busy,
    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [$clog2(DEPTH):0]  wb_pending,
    output logic                    err_load
`ifdef RISCV_WB_FORWARD_EN
    ,
    output logic                    fwd_valid,
    output logic [REG_AW-1:0]       fwd_rd,
    output logic [XLEN-1:0]         fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ---------------------------------------------------------------------
    // Value formation at accept time
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] load_data;
    logic            load_err;
    logic [XLEN-1:0] wb_value;
    logic            is_mem;
    logic            accept;
    logic            store;
    logic            pop;

    wb_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3_i  (wb_funct3),
        .addr_lo_i (wb_addr_lo),
        .rdata_i   (mem_rdata),
        .data_o    (load_data),
        .err_o     (load_err)
    );

    always_comb begin
        is_mem   = (wb_src == WB_MEM);
        wb_value = alu_result;
        case (wb_src)
            WB_MEM:  wb_value = load_data;
            WB_PC4:  wb_value = pc + XLEN'(4);
            default: wb_value = alu_result;
        endcase
    end

    // Handshake completes for x0 and for bad loads too; those simply never
    // occupy a FIFO slot.
    assign accept = wb_valid && wb_ready;
    assign store  = accept && (wb_rd != '0) && !(is_mem && load_err);

    // ---------------------------------------------------------------------
    // Result FIFO
    // ---------------------------------------------------------------------
    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              err_load_q, err_load_d;

    // Ready looks only at the registered occupancy, so rf_busy never reaches
    // the upstream handshake combinationally.
    assign wb_ready = (count_q < FULL_CNT);
    assign pop      = (count_q != '0) && !rf_busy;

    always_ff @(posedge clk) begin
        if (store) begin
            rd_mem[wr_ptr_q]   <= wb_rd;
            data_mem[wr_ptr_q] <= wb_value;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_load_d = accept && is_mem && load_err;

        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_mem[rd_ptr_q];
            rf_wdata_d = data_mem[rd_ptr_q];
        end

        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_load_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_load_q <= err_load_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign err_load   = err_load_q;
    assign wb_pending = count_q;

`ifdef RISCV_WB_FORWARD_EN
    // Shadow copy of the most recently stored entry. Since the FIFO is strictly
    // in order, the last store is always the youngest entry while anything is
    // still buffered, which gives "newest wins" for repeated rd automatically.
    logic [REG_AW-1:0] fwd_rd_q, fwd_rd_d;
    logic [XLEN-1:0]   fwd_data_q, fwd_data_d;

    always_comb begin
        fwd_rd_d   = fwd_rd_q;
        fwd_data_d = fwd_data_q;
        if (store) begin
            fwd_rd_d   = wb_rd;
            fwd_data_d = wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_rd_q   <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_rd_q   <= fwd_rd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign fwd_valid = (count_q != '0);
    assign fwd_rd    = fwd_rd_q;
    assign fwd_data  = fwd_data_q;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
    import riscv_wb_pkg::*;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 2;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_valid = 1'b0;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_rd = '0;
    logic [1:0]        wb_src = '0;
    logic [2:0]        wb_funct3 = '0;
    logic [1:0]        wb_addr_lo = '0;
    logic [XLEN-1:0]   alu_result = '0;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic [XLEN-1:0]   pc = '0;
    logic              rf_busy = 1'b0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [1:0]        wb_pending;
    logic              err_load;
`ifdef RISCV_WB_FORWARD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
`endif

    always #5 clk = ~clk;

    reg_writeback #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_src     (wb_src),
        .wb_funct3  (wb_funct3),
        .wb_addr_lo (wb_addr_lo),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .rf_busy    (rf_busy),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .wb_pending (wb_pending),
        .err_load   (err_load)
`ifdef RISCV_WB_FORWARD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending writes plus the expected registered
    // write-port and error outputs after each clock edge.
    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
    } ent_t;

    ent_t      q[$];
    bit        exp_we;
    bit [4:0]  exp_waddr;
    bit [31:0] exp_wdata;
    bit        exp_err;

    function automatic void ref_value(input bit [1:0] src, input bit [2:0] f3, input bit [1:0] a,
                                      input bit [31:0] alu, input bit [31:0] mem, input bit [31:0] pcv,
                                      output bit ok, output bit [31:0] v);
        bit [31:0] b;
        bit [31:0] h;
        ok = 1'b1;
        v  = alu;
        b  = (mem >> (8 * a)) & 32'hFF;
        h  = (mem >> (16 * a[1])) & 32'hFFFF;
        if (src == 2'd2) begin
            v = pcv + 32'd4;
        end else if (src == 2'd1) begin
            case (f3)
                3'd0: v = (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
                3'd4: v = b;
                3'd1: begin ok = (a[0] == 1'b0); v = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h; end
                3'd5: begin ok = (a[0] == 1'b0); v = h; end
                3'd2: begin ok = (a == 2'd0); v = mem; end
                default: ok = 1'b0;
            endcase
        end
    endfunction

    // Advance model and DUT by one clock with the currently driven inputs.
    task automatic step();
        bit        ok;
        bit [31:0] v;
        bit        acc;
        ent_t      e;
        if (!rst) begin
            q.delete();
            exp_we    = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
            exp_err   = 1'b0;
        end else begin
            acc = wb_valid && (q.size() < DEPTH);
            if (q.size() != 0 && !rf_busy) begin
                exp_we    = 1'b1;
                exp_waddr = q[0].rd;
                exp_wdata = q[0].data;
                void'(q.pop_front());
            end else begin
                exp_we = 1'b0;
            end
            ref_value(wb_src, wb_funct3, wb_addr_lo, alu_result, mem_rdata, pc, ok, v);
            exp_err = 1'b0;
            if (acc) begin
                if (wb_src == 2'd1 && !ok) begin
                    exp_err = 1'b1;
                end else if (wb_rd != 0) begin
                    e.rd   = wb_rd;
                    e.data = v;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input bit [4:0] rd, input bit [1:0] src, input bit [2:0] f3,
                         input bit [1:0] a, input bit [31:0] alu, input bit [31:0] mem);
        wb_valid   = 1'b1;
        wb_rd      = rd;
        wb_src     = src;
        wb_funct3  = f3;
        wb_addr_lo = a;
        alu_result = alu;
        mem_rdata  = mem;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wb_valid = 1'b0;
        step();
        step();
        checks++;
        if (rf_we !== 1'b0 || err_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got we=%0d err=%0d, want 0/0", rf_we, err_load);
        end
        checks++;
        if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_port: got waddr=%0d wdata=%h, want 0/0", rf_waddr, rf_wdata);
        end
        checks++;
        if (wb_pending !== 2'd0 || wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got pending=%0d ready=%0d, want 0/1", wb_pending, wb_ready);
        end
`ifdef RISCV_WB_FORWARD_EN
        checks++;
        if (fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fwd: got fwd_valid=%0d, want 0", fwd_valid);
        end
`endif
        rst = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_alu();
        offer(5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'd0);
        step();
        wb_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || wb_pending !== 2'd1) begin
            errors++;
            $display("FAIL alu_accept: got we=%0d pending=%0d, want 0/1", rf_we, wb_pending);
        end
        step();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_write: got we=%0d rd=%0d data=%h, want 1/5/12345678", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_hold: got we=%0d rd=%0d data=%h, want 0/5/12345678", rf_we, rf_waddr, rf_wdata);
        end
        $display("test_alu done: rd=%0d data=%h", rf_waddr, rf_wdata);
    endtask

    task automatic test_loads();
        bit [2:0]  f3_t  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        bit [1:0]  a_t   [4] = '{2'd3, 2'd3, 2'd2, 2'd2};
        bit [31:0] exp_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        for (int i = 0; i < 4; i++) begin
            offer(5'(10 + i), 2'd1, f3_t[i], a_t[i], 32'd0, 32'h80FF_0011);
            step();
            wb_valid = 1'b0;
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== exp_t[i]) begin
                errors++;
                $display("FAIL load_%0d: got we=%0d rd=%0d data=%h, want 1/%0d/%h",
                         i, rf_we, rf_waddr, rf_wdata, 10 + i, exp_t[i]);
            end
            $display("load f3=%0d addr=%0d -> %h", f3_t[i], a_t[i], rf_wdata);
        end
        step();
    endtask

    task automatic test_errors();
        offer(5'd7, 2'd1, 3'd2, 2'd1, 32'd0, 32'hDEAD_BEEF);
        step();
        wb_valid = 1'b0;
        checks++;
        if (err_load !== 1'b1 || wb_pending !== 2'd0) begin
            errors++;
            $display("FAIL lw_misalign: got err=%0d pending=%0d, want 1/0", err_load, wb_pending);
        end
        step();
        checks++;
        if (err_load !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_pulse: got err=%0d we=%0d, want 0/0", err_load, rf_we);
        end
        offer(5'd0, 2'd0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'd0);
        step();
        wb_valid = 1'b0;
        checks++;
        if (err_load !== 1'b0 || wb_pending !== 2'd0) begin
            errors++;
            $display("FAIL x0_accept: got err=%0d pending=%0d, want 0/0", err_load, wb_pending);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: got we=%0d, want 0", rf_we);
        end
        $display("test_errors done");
    endtask

    task automatic test_back_to_back();
        bit [4:0] order[$];
        bit       c_taken = 1'b0;
        rf_busy = 1'b1;
        offer(5'd20, 2'd0, 3'd0, 2'd0, 32'hA0, 32'd0);
        step();
        offer(5'd21, 2'd0, 3'd0, 2'd0, 32'hA1, 32'd0);
        step();
        offer(5'd22, 2'd0, 3'd0, 2'd0, 32'hA2, 32'd0);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (wb_ready !== 1'b0 || wb_pending !== 2'd2 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL busy_full: got ready=%0d pending=%0d we=%0d, want 0/2/0", wb_ready, wb_pending, rf_we);
        end
        rf_busy = 1'b0;
        for (int i = 0; i < 10 && order.size() < 3; i++) begin
            if (wb_valid && wb_ready) c_taken = 1'b1;
            step();
            if (c_taken) wb_valid = 1'b0;
            checks++;
            if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL drain_model: got we=%0d rd=%0d data=%h, want %0d/%0d/%h",
                         rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
            end
            if (rf_we) begin
                order.push_back(rf_waddr);
                $display("drain write rd=%0d data=%h", rf_waddr, rf_wdata);
            end
        end
        checks++;
        if (order.size() != 3) begin
            errors++;
            $display("FAIL drain_count: got %0d writes, want 3", order.size());
        end else if (order[0] != 5'd20 || order[1] != 5'd21 || order[2] != 5'd22) begin
            errors++;
            $display("FAIL drain_order: got %0d,%0d,%0d, want 20,21,22", order[0], order[1], order[2]);
        end
        wb_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        rf_busy = 1'b1;
        offer(5'd1, 2'd0, 3'd0, 2'd0, 32'h11, 32'd0);
        step();
        offer(5'd2, 2'd2, 3'd0, 2'd0, 32'h22, 32'd0);
        step();
        wb_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        rf_busy = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || wb_pending !== 2'd0 || wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got we=%0d pending=%0d ready=%0d, want 0/0/1", rf_we, wb_pending, wb_ready);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_discard: got we=%0d after reset, want 0", rf_we);
        end
        $display("test_reset_mid done");
    endtask

`ifdef RISCV_WB_FORWARD_EN
    task automatic test_forward();
        rf_busy = 1'b1;
        offer(5'd3, 2'd0, 3'd0, 2'd0, 32'hA, 32'd0);
        step();
        offer(5'd3, 2'd0, 3'd0, 2'd0, 32'hB, 32'd0);
        step();
        wb_valid = 1'b0;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'hB) begin
            errors++;
            $display("FAIL fwd_newest: got v=%0d rd=%0d data=%h, want 1/3/0000000b", fwd_valid, fwd_rd, fwd_data);
        end
        rf_busy = 1'b0;
        step();
        step();
        checks++;
        if (fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_empty: got fwd_valid=%0d, want 0", fwd_valid);
        end
        $display("test_forward done");
    endtask
`endif

    task automatic test_random();
        bit [1:0] exp_pending;
        bit       exp_ready;
        for (int i = 0; i < 300; i++) begin
            wb_valid   = ($urandom_range(0, 3) != 0);
            wb_rd      = 5'($urandom_range(0, 31));
            wb_src     = 2'($urandom_range(0, 3));
            wb_funct3  = 3'($urandom_range(0, 7));
            wb_addr_lo = 2'($urandom_range(0, 3));
            alu_result = $urandom;
            mem_rdata  = $urandom;
            pc         = $urandom;
            rf_busy    = ($urandom_range(0, 2) == 0);
            step();
            exp_pending = 2'(q.size());
            exp_ready   = (q.size() < DEPTH);
            checks++;
            if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata ||
                err_load !== exp_err || wb_pending !== exp_pending || wb_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_%0d: got we=%0d rd=%0d data=%h err=%0d pend=%0d rdy=%0d, want %0d/%0d/%h/%0d/%0d/%0d",
                         i, rf_we, rf_waddr, rf_wdata, err_load, wb_pending, wb_ready,
                         exp_we, exp_waddr, exp_wdata, exp_err, exp_pending, exp_ready);
            end
`ifdef RISCV_WB_FORWARD_EN
            if (q.size() != 0) begin
                checks++;
                if (fwd_valid !== 1'b1 || fwd_rd !== q[$].rd || fwd_data !== q[$].data) begin
                    errors++;
                    $display("FAIL rand_fwd_%0d: got v=%0d rd=%0d data=%h, want 1/%0d/%h",
                             i, fwd_valid, fwd_rd, fwd_data, q[$].rd, q[$].data);
                end
            end
`endif
            if (rf_we) $display("rand %0d write rd=%0d data=%h", i, rf_waddr, rf_wdata);
        end
        wb_valid = 1'b0;
        rf_busy  = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid();
`ifdef RISCV_WB_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
